// File: rtl/cpu_boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// ioctl bus widths and the address range helper.
package cpu_boot_loader_pkg;

    localparam int IOCTL_ADDR_W  = 25;
    localparam int IOCTL_DATA_W  = 16;
    localparam int IOCTL_INDEX_W = 8;

    typedef enum logic [2:0] {
        HOLD,
        RUN,
        LIDLE,
        LLO,
        LHI
    } state_t;

    // True when a download byte address lands inside a 2**addr_w byte memory.
    function automatic logic in_range(input logic [IOCTL_ADDR_W-1:0] byte_addr,
                                      input int addr_w);
        return (byte_addr >> addr_w) == '0;
    endfunction

endpackage

// File: rtl/cpu_boot_loader_if.sv
// Bus bundle between hps_io / CPU core (master side) and the boot loader (slave side).
interface cpu_boot_loader_if
    import cpu_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 12
);

    logic                     ioctl_download;
    logic [IOCTL_INDEX_W-1:0] ioctl_index;
    logic                     ioctl_wr;
    logic [IOCTL_ADDR_W-1:0]  ioctl_addr;
    logic [IOCTL_DATA_W-1:0]  ioctl_dout;
    logic                     ioctl_wait;

    logic [ADDR_W-1:0]        cpu_addr;
    logic                     cpu_wr;
    logic [7:0]               cpu_dout;
    logic [7:0]               cpu_din;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait,
        output cpu_addr, cpu_wr, cpu_dout,
        input  cpu_din
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait,
        input  cpu_addr, cpu_wr, cpu_dout,
        output cpu_din
    );

endinterface

// File: rtl/cpu_boot_loader_boot_ram.sv
// Single-port 2**ADDR_W x 8 synchronous RAM with registered read data.
// Read-before-write; no reset, so content survives reset_n.
module cpu_boot_loader_boot_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [7:0]        data,
    output logic [7:0]        q
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot-memory controller: fills the boot RAM from 16-bit ioctl downloads,
// holds the CPU in reset after power-up and downloads, then serves CPU accesses.
module cpu_boot_loader
    import cpu_boot_loader_pkg::*;
#(
    parameter int         ADDR_W       = 12,
    parameter int         RESET_CYCLES = 256,
    parameter logic [7:0] ROM_INDEX    = 8'd0,
    parameter bit         WRITABLE     = 1'b0
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    cpu_boot_loader_if.slave      bus,
    output logic                  cpu_reset,
    output logic                  copy_in_progress,
    output logic [ADDR_W:0]       load_size,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(RESET_CYCLES) + 1;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        hold_cnt;
    logic                    download_prev;
    logic                    start;
    logic                    ioctl_wait_q;

    logic [IOCTL_ADDR_W-1:0] addr_q;
    logic [IOCTL_DATA_W-1:0] data_q;
    logic [IOCTL_ADDR_W-1:0] hi_addr;
    logic                    lo_we;
    logic                    hi_we;

    logic [IOCTL_ADDR_W-1:0] byte_addr;
    logic                    byte_ok;
    logic [ADDR_W:0]         byte_size;

    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_we;
    logic [7:0]              ram_data;

    assign hi_addr = addr_q + IOCTL_ADDR_W'(1);

    always_comb begin
        start      = bus.ioctl_download && !download_prev && (bus.ioctl_index == ROM_INDEX);
        next_state = state;
        case (state)
            HOLD:    if (hold_cnt == CNT_W'(RESET_CYCLES - 1)) next_state = RUN;
            RUN:     next_state = RUN;
            LIDLE: begin
                if (!bus.ioctl_download) begin
                    next_state = HOLD;
                end else if (bus.ioctl_wr) begin
                    next_state = LLO;
                end
            end
            LLO:     next_state = LHI;
            LHI:     next_state = bus.ioctl_download ? LIDLE : HOLD;
            default: next_state = HOLD;
        endcase
        if (start) begin
            next_state = LIDLE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            download_prev <= 1'b0;
            ioctl_wait_q  <= 1'b0;
        end else begin
            state         <= next_state;
            download_prev <= bus.ioctl_download;
            ioctl_wait_q  <= (next_state == LLO) || (next_state == LHI);
            hold_cnt      <= (state == HOLD && next_state == HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    // Captured word and byte strobes live outside the reset domain: a byte whose
    // write cycle has already begun still lands in RAM if reset_n pulses.
    always_ff @(posedge clk_sys) begin
        if (state == LIDLE && next_state == LLO) begin
            addr_q <= bus.ioctl_addr;
            data_q <= bus.ioctl_dout;
        end
        lo_we <= (state == LIDLE) && (next_state == LLO) && in_range(bus.ioctl_addr, ADDR_W);
        hi_we <= (state == LLO) && (next_state == LHI) && in_range(hi_addr, ADDR_W);
    end

    always_comb begin
        byte_addr = (state == LHI) ? hi_addr : addr_q;
        byte_ok   = in_range(byte_addr, ADDR_W);
        byte_size = {1'b0, byte_addr[ADDR_W-1:0]} + (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            load_size <= '0;
            overflow  <= 1'b0;
        end else if (start) begin
            load_size <= '0;
            overflow  <= 1'b0;
        end else if (state == LLO || state == LHI) begin
            if (!byte_ok) begin
                overflow <= 1'b1;
            end else if (byte_size > load_size) begin
                load_size <= byte_size;
            end
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = bus.cpu_addr;
        ram_data = bus.cpu_dout;
        if (lo_we) begin
            ram_we   = 1'b1;
            ram_addr = addr_q[ADDR_W-1:0];
            ram_data = data_q[7:0];
        end else if (hi_we) begin
            ram_we   = 1'b1;
            ram_addr = hi_addr[ADDR_W-1:0];
            ram_data = data_q[15:8];
        end else if (state == RUN) begin
            ram_we = bus.cpu_wr && WRITABLE && !start;
        end else if (state != HOLD) begin
            ram_addr = addr_q[ADDR_W-1:0];
        end
    end

    cpu_boot_loader_boot_ram #(
        .ADDR_W (ADDR_W)
    ) boot_ram (
        .clk  (clk_sys),
        .addr (ram_addr),
        .we   (ram_we),
        .data (ram_data),
        .q    (bus.cpu_din)
    );

    assign bus.ioctl_wait    = ioctl_wait_q;
    assign cpu_reset         = (state != RUN);
    assign copy_in_progress  = (state == LIDLE) || (state == LLO) || (state == LHI);

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: a ROM (WRITABLE=0) and a RAM (WRITABLE=1)
// instance share identical stimulus; expected values are hand-computed.
module tb_cpu_boot_loader;

    localparam int ADDR_W = 12;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr;
    logic [7:0]        cpu_dout;

    logic              cpu_reset0, cpu_reset1;
    logic              copy0, copy1;
    logic [ADDR_W:0]   size0, size1;
    logic              ovf0, ovf1;

    int tests_run    = 0;
    int tests_failed = 0;
    int n;
    int waits;
    logic copy_seen;

    always #5 clk_sys = ~clk_sys;

    cpu_boot_loader_if #(.ADDR_W(ADDR_W)) bus0 ();
    cpu_boot_loader_if #(.ADDR_W(ADDR_W)) bus1 ();

    assign bus0.ioctl_download = ioctl_download;
    assign bus0.ioctl_index    = ioctl_index;
    assign bus0.ioctl_wr       = ioctl_wr;
    assign bus0.ioctl_addr     = ioctl_addr;
    assign bus0.ioctl_dout     = ioctl_dout;
    assign bus0.cpu_addr       = cpu_addr;
    assign bus0.cpu_wr         = cpu_wr;
    assign bus0.cpu_dout       = cpu_dout;
    assign bus1.ioctl_download = ioctl_download;
    assign bus1.ioctl_index    = ioctl_index;
    assign bus1.ioctl_wr       = ioctl_wr;
    assign bus1.ioctl_addr     = ioctl_addr;
    assign bus1.ioctl_dout     = ioctl_dout;
    assign bus1.cpu_addr       = cpu_addr;
    assign bus1.cpu_wr         = cpu_wr;
    assign bus1.cpu_dout       = cpu_dout;

    cpu_boot_loader #(.ADDR_W(ADDR_W), .RESET_CYCLES(256), .ROM_INDEX(8'd0), .WRITABLE(1'b0)) dut0 (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .bus              (bus0),
        .cpu_reset        (cpu_reset0),
        .copy_in_progress (copy0),
        .load_size        (size0),
        .overflow         (ovf0)
    );

    cpu_boot_loader #(.ADDR_W(ADDR_W), .RESET_CYCLES(256), .ROM_INDEX(8'd0), .WRITABLE(1'b1)) dut1 (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .bus              (bus1),
        .cpu_reset        (cpu_reset1),
        .copy_in_progress (copy1),
        .load_size        (size1),
        .overflow         (ovf1)
    );

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Counts consecutive negedge samples with cpu_reset high, bounded at 1000.
    task automatic measure_hold(output int cycles, output logic copy_hi);
        cycles  = 0;
        copy_hi = 1'b0;
        while (cpu_reset0 && cycles < 1000) begin
            cycles++;
            copy_hi = copy_hi | copy0;
            @(negedge clk_sys);
        end
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic send_word(input logic [24:0] addr, input logic [15:0] data, output int wait_cycles);
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        wait_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            if (bus0.ioctl_wait) wait_cycles++;
        end
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [7:0] expected);
        cpu_addr = addr;
        @(negedge clk_sys);
        check_output(tag, bus0.cpu_din, expected);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_addr       = '0;
        cpu_wr         = 1'b0;
        cpu_dout       = '0;
        repeat (3) @(negedge clk_sys);

        check_output("rst_cpu_reset", cpu_reset0, 1);
        check_output("rst_wait", bus0.ioctl_wait, 0);
        check_output("rst_copy", copy0, 0);
        check_output("rst_load_size", size0, 0);
        check_output("rst_overflow", ovf0, 0);

        reset_n = 1'b1;
        measure_hold(n, copy_seen);
        check_output("por_hold_cycles", n, 256);
        check_output("por_copy_low", copy_seen, 0);
        check_output("por_run", cpu_reset0, 0);

        start_download(8'd0);
        check_output("dl_cpu_reset", cpu_reset0, 1);
        check_output("dl_copy", copy0, 1);
        send_word(25'h0, 16'h3E01, waits);
        check_output("w0_wait_pulse", waits, 2);
        send_word(25'h2, 16'h76C9, waits);
        check_output("w1_wait_pulse", waits, 2);
        check_output("dl_load_size", size0, 4);
        check_output("dl_overflow", ovf0, 0);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        measure_hold(n, copy_seen);
        check_output("dl_hold_cycles", n, 256);
        check_output("dl_hold_copy", copy_seen, 0);
        read_check("rd1", 12'h001, 8'h3E);
        read_check("rd0", 12'h000, 8'h01);
        read_check("rd2", 12'h002, 8'hC9);
        read_check("rd3", 12'h003, 8'h76);

        start_download(8'd0);
        check_output("run_dl_cpu_reset", cpu_reset0, 1);
        check_output("run_dl_size_clr", size0, 0);
        send_word(25'hFFE, 16'hBEEF, waits);
        check_output("top_size", size0, 13'h1000);
        check_output("top_overflow", ovf0, 0);
        send_word(25'h1000, 16'h5A5A, waits);
        check_output("oob_overflow", ovf0, 1);
        check_output("oob_size", size0, 13'h1000);
        send_word(25'h8, 16'h1111, waits);
        send_word(25'h4, 16'h1234, waits);
        check_output("low_size_max", size0, 13'h1000);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        measure_hold(n, copy_seen);
        check_output("dl2_hold_cycles", n, 256);
        check_output("ovf_sticky", ovf0, 1);
        read_check("rd_ffe", 12'hFFE, 8'hEF);
        read_check("rd_fff", 12'hFFF, 8'hBE);
        read_check("rd0_kept", 12'h000, 8'h01);
        read_check("rd1_kept", 12'h001, 8'h3E);
        read_check("rd4", 12'h004, 8'h34);
        read_check("rd5", 12'h005, 8'h12);

        start_download(8'd1);
        check_output("idx1_cpu_reset", cpu_reset0, 0);
        check_output("idx1_copy", copy0, 0);
        send_word(25'h0, 16'hFFFF, waits);
        check_output("idx1_no_wait", waits, 0);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        read_check("idx1_rd0", 12'h000, 8'h01);
        check_output("idx1_ovf_kept", ovf0, 1);

        cpu_addr = 12'h005;
        cpu_dout = 8'hAA;
        cpu_wr   = 1'b1;
        @(negedge clk_sys);
        cpu_wr = 1'b0;
        @(negedge clk_sys);
        check_output("rom_wr_dropped", bus0.cpu_din, 8'h12);
        check_output("ram_wr_taken", bus1.cpu_din, 8'hAA);

        start_download(8'd0);
        ioctl_addr = 25'h8;
        ioctl_dout = 16'h5678;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        check_output("llo_wait", bus0.ioctl_wait, 1);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        reset_n        = 1'b0;
        #1;
        check_output("mid_rst_cpu_reset", cpu_reset0, 1);
        check_output("mid_rst_wait", bus0.ioctl_wait, 0);
        check_output("mid_rst_copy", copy0, 0);
        check_output("mid_rst_size", size0, 0);
        check_output("mid_rst_overflow", ovf0, 0);
        #1;
        reset_n = 1'b1;
        measure_hold(n, copy_seen);
        check_output("mid_rst_hold_cycles", n, 256);
        read_check("rd8_lo_written", 12'h008, 8'h78);
        read_check("rd9_hi_kept", 12'h009, 8'h11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
